// File: rtl/pc_sequencer.sv
// Next-PC controller for the multi-cycle MIPS32 core: sequences
// fetch/decode/branch/wait/halt and produces the PC write strobe and value.
module pc_sequencer #(
    parameter logic [5:0] HALT_OP  = 6'b111111,
    parameter logic [5:0] JR_FUNCT = 6'b001000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        run,
    input  logic [31:0] pc,
    input  logic        imem_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_data,
    input  logic        zero,
    input  logic        exec_done,
    output logic        PCcontrol,
    output logic [31:0] PC0,
    output logic        IRWrite,
    output logic        link_we,
    output logic [31:0] link_pc,
    output logic        align_err,
    output logic        halted,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_BRANCH = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    logic [2:0]  state_nxt;
    logic [31:0] link_pc_nxt;
    logic        br_bne;
    logic        br_bne_nxt;
    logic [31:0] br_off;
    logic        br_taken;

    // Sign-extended word offset and taken decision for the latched branch kind
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_taken = br_bne ? ~zero : zero;

    // State, link address and branch-kind registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            link_pc <= 32'h0;
            br_bne  <= 1'b0;
        end else begin
            state   <= state_nxt;
            link_pc <= link_pc_nxt;
            br_bne  <= br_bne_nxt;
        end
    end

    // Next-state decode and single-cycle strobes
    always_comb begin
        state_nxt   = state;
        link_pc_nxt = link_pc;
        br_bne_nxt  = br_bne;
        PCcontrol   = 1'b0;
        PC0         = 32'h0;
        IRWrite     = 1'b0;
        link_we     = 1'b0;
        align_err   = 1'b0;
        halted      = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // Dropping run wins over a ready instruction
                if (!run) begin
                    state_nxt = S_IDLE;
                end else if (imem_ready) begin
                    IRWrite     = 1'b1;
                    PCcontrol   = 1'b1;
                    PC0         = pc + 32'd4;
                    link_pc_nxt = pc + 32'd4;
                    state_nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == HALT_OP) begin
                    state_nxt = S_HALT;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    PCcontrol = 1'b1;
                    PC0       = {link_pc[31:28], jtarget, 2'b00};
                    link_we   = (opcode == OP_JAL);
                    state_nxt = S_FETCH;
                end else if (opcode == OP_RTYPE && funct == JR_FUNCT) begin
                    PCcontrol = 1'b1;
                    PC0       = {rs_data[31:2], 2'b00};
                    align_err = |rs_data[1:0];
                    state_nxt = S_FETCH;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    br_bne_nxt = (opcode == OP_BNE);
                    state_nxt  = S_BRANCH;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_BRANCH: begin
                if (br_taken) begin
                    PCcontrol = 1'b1;
                    PC0       = link_pc + br_off;
                end
                state_nxt = S_FETCH;
            end
            S_WAIT: begin
                if (exec_done) state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer.
module tb_pc_sequencer;

    logic        CLK;
    logic        Reset;
    logic        run;
    logic [31:0] pc;
    logic        imem_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rs_data;
    logic        zero;
    logic        exec_done;
    logic        PCcontrol;
    logic [31:0] PC0;
    logic        IRWrite;
    logic        link_we;
    logic [31:0] link_pc;
    logic        align_err;
    logic        halted;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .CLK(CLK), .Reset(Reset), .run(run), .pc(pc), .imem_ready(imem_ready),
        .opcode(opcode), .funct(funct), .imm16(imm16), .jtarget(jtarget),
        .rs_data(rs_data), .zero(zero), .exec_done(exec_done),
        .PCcontrol(PCcontrol), .PC0(PC0), .IRWrite(IRWrite), .link_we(link_we),
        .link_pc(link_pc), .align_err(align_err), .halted(halted), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        run;
        logic        rdy;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] rs;
        logic        zero;
        logic        ed;
        logic        e_pcc;
        logic [31:0] e_pc0;
        logic        e_irw;
        logic        e_lw;
        logic        e_ae;
        logic        e_halt;
        logic [2:0]  e_state;
        logic [31:0] e_link;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic r, logic rd, logic [31:0] p, logic [5:0] o, logic [5:0] f,
                                logic [15:0] im, logic [25:0] j, logic [31:0] rs, logic z, logic e,
                                logic pcc, logic [31:0] pc0, logic irw, logic lw, logic ae,
                                logic hl, logic [2:0] st, logic [31:0] lk);
        vec_t v;
        v.run = r; v.rdy = rd; v.pc = p; v.op = o; v.fn = f; v.imm = im; v.jt = j; v.rs = rs;
        v.zero = z; v.ed = e; v.e_pcc = pcc; v.e_pc0 = pc0; v.e_irw = irw; v.e_lw = lw;
        v.e_ae = ae; v.e_halt = hl; v.e_state = st; v.e_link = lk;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " PCcontrol"}, 32'(PCcontrol), 32'h0);
        chk({tag, " PC0"},       PC0,            32'h0);
        chk({tag, " IRWrite"},   32'(IRWrite),   32'h0);
        chk({tag, " link_we"},   32'(link_we),   32'h0);
        chk({tag, " align_err"}, 32'(align_err), 32'h0);
        chk({tag, " halted"},    32'(halted),    32'h0);
        chk({tag, " state"},     32'(state),     32'h0);
        chk({tag, " link_pc"},   link_pc,        32'h0);
    endtask

    initial begin
        string tag;
        Reset = 1'b0; run = 1'b0; pc = 32'h0; imem_ready = 1'b0; opcode = 6'h0;
        funct = 6'h0; imm16 = 16'h0; jtarget = 26'h0; rs_data = 32'h0; zero = 1'b0;
        exec_done = 1'b0;

        //   run rdy pc            op     fn     imm       jt          rs            z  ed  pcc pc0           irw lw ae hl st  link
        add(1, 0, 32'h0,        6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 1, 32'h0);
        add(1, 1, 32'h0,        6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h4,        1, 0, 0, 0, 2, 32'h4);
        add(1, 1, 32'h4,        6'h23, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 4, 32'h4);
        for (int i = 0; i < 5; i++)
            add(1, 1, 32'h4,    6'h23, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 4, 32'h4);
        add(1, 1, 32'h4,        6'h23, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 1,  0, 32'h0,        0, 0, 0, 0, 1, 32'h4);
        // beq taken, backwards one word
        add(1, 1, 32'hFC,       6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h100,      1, 0, 0, 0, 2, 32'h100);
        add(1, 1, 32'h100,      6'h04, 6'h00, 16'hFFFF, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 3, 32'h100);
        add(1, 1, 32'h100,      6'h04, 6'h00, 16'hFFFF, 26'h0,       32'h0,     1, 0,  1, 32'hFC,       0, 0, 0, 0, 1, 32'h100);
        // beq not taken
        add(1, 1, 32'hFC,       6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h100,      1, 0, 0, 0, 2, 32'h100);
        add(1, 1, 32'h100,      6'h04, 6'h00, 16'hFFFF, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 3, 32'h100);
        add(1, 1, 32'h100,      6'h04, 6'h00, 16'hFFFF, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 1, 32'h100);
        // bne taken with zero=0, forward 16 words
        add(1, 1, 32'hFC,       6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h100,      1, 0, 0, 0, 2, 32'h100);
        add(1, 1, 32'h100,      6'h05, 6'h00, 16'h0010, 26'h0,       32'h0,     1, 0,  0, 32'h0,        0, 0, 0, 0, 3, 32'h100);
        add(1, 1, 32'h100,      6'h05, 6'h00, 16'h0010, 26'h0,       32'h0,     0, 0,  1, 32'h140,      0, 0, 0, 0, 1, 32'h100);
        // jal keeps the upper nibble of link_pc
        add(1, 1, 32'h8000000C, 6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h80000010, 1, 0, 0, 0, 2, 32'h80000010);
        add(1, 1, 32'h80000010, 6'h03, 6'h00, 16'h0000, 26'h40,      32'h0,     0, 0,  1, 32'h80000100, 0, 1, 0, 0, 1, 32'h80000010);
        // jr misaligned
        add(1, 1, 32'h1FC,      6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h200,      1, 0, 0, 0, 2, 32'h200);
        add(1, 1, 32'h200,      6'h00, 6'h08, 16'h0000, 26'h0,       32'h203,   0, 0,  1, 32'h200,      0, 0, 1, 0, 1, 32'h200);
        // imem not ready three cycles, exec_done ignored, then run dropped with ready
        for (int i = 0; i < 3; i++)
            add(1, 0, 32'h200,  6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 1,  0, 32'h0,        0, 0, 0, 0, 1, 32'h200);
        add(0, 1, 32'h200,      6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h200);
        add(0, 1, 32'h200,      6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h200);
        add(1, 1, 32'h200,      6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 1, 32'h200);
        // j with full-width target
        add(1, 1, 32'h3FC,      6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h400,      1, 0, 0, 0, 2, 32'h400);
        add(1, 1, 32'h400,      6'h02, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0,     0, 0,  1, 32'h0FFFFFFC, 0, 0, 0, 0, 1, 32'h400);
        // pc+4 wraps to zero, then aligned jr
        add(1, 1, 32'hFFFFFFFC, 6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h0,        1, 0, 0, 0, 2, 32'h0);
        add(1, 1, 32'h0,        6'h00, 6'h08, 16'h0000, 26'h0,       32'h1000,  0, 0,  1, 32'h1000,     0, 0, 0, 0, 1, 32'h0);
        // halt is sticky
        add(1, 1, 32'h10,       6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  1, 32'h14,       1, 0, 0, 0, 2, 32'h14);
        add(1, 1, 32'h14,       6'h3F, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 0, 5, 32'h14);
        add(0, 0, 32'h14,       6'h00, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 0,  0, 32'h0,        0, 0, 0, 1, 5, 32'h14);
        add(1, 1, 32'h14,       6'h02, 6'h00, 16'h0000, 26'h0,       32'h0,     0, 1,  0, 32'h0,        0, 0, 0, 1, 5, 32'h14);

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk_idle_outputs("reset");
        @(negedge CLK);
        Reset = 1'b1;

        foreach (vq[k]) begin
            vec_t v;
            v = vq[k];
            run = v.run; imem_ready = v.rdy; pc = v.pc; opcode = v.op; funct = v.fn;
            imm16 = v.imm; jtarget = v.jt; rs_data = v.rs; zero = v.zero; exec_done = v.ed;
            #1;
            tag = $sformatf("v%0d", k);
            chk({tag, " PCcontrol"}, 32'(PCcontrol), 32'(v.e_pcc));
            chk({tag, " PC0"},       PC0,            v.e_pc0);
            chk({tag, " IRWrite"},   32'(IRWrite),   32'(v.e_irw));
            chk({tag, " link_we"},   32'(link_we),   32'(v.e_lw));
            chk({tag, " align_err"}, 32'(align_err), 32'(v.e_ae));
            chk({tag, " halted"},    32'(halted),    32'(v.e_halt));
            @(posedge CLK);
            #1;
            chk({tag, " state"},     32'(state),     32'(v.e_state));
            chk({tag, " link_pc"},   link_pc,        v.e_link);
            @(negedge CLK);
        end

        // Async reset out of halt, no clock edge needed
        #2;
        Reset = 1'b0;
        #1;
        chk_idle_outputs("rst_halt");
        @(negedge CLK);
        Reset = 1'b1;
        run = 1'b1; imem_ready = 1'b0; exec_done = 1'b0; opcode = 6'h00;
        @(posedge CLK);
        #1;
        chk("rst2 state", 32'(state), 32'd1);

        // Reset mid-fetch kills strobes and the pending PC/link update
        @(negedge CLK);
        imem_ready = 1'b1; pc = 32'h20;
        #1;
        chk("midfetch PCcontrol", 32'(PCcontrol), 32'h1);
        chk("midfetch PC0", PC0, 32'h24);
        #1;
        Reset = 1'b0;
        #1;
        chk_idle_outputs("rst_fetch");
        @(posedge CLK);
        #1;
        chk("rst_fetch held state", 32'(state), 32'd0);
        chk("rst_fetch held link", link_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
